// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, FSM state encoding and divide length for the FIR receive path.
package fir_pkg;
  localparam int XW = 16;
  localparam int HW = 16;
  localparam int YW = 32;
  localparam int DIV_CYC = YW;
  typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/fir_seq_div.sv
// fir_seq_div: signed restoring divider, one quotient bit per cycle, truncating toward zero.
module fir_seq_div #(
  parameter int NW = 32,
  parameter int DW = 16
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [NW-1:0] num,
  input  logic signed [DW-1:0] den,
  output logic                 busy,
  output logic                 done,
  output logic signed [NW-1:0] quo,
  output logic signed [DW-1:0] rem
);
  localparam int CW = $clog2(NW);
  logic [NW-1:0] a_q, a_d;
  logic [DW-1:0] r_q, r_d, d_q, d_d, rn;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic [DW:0] rs;
  logic ge, last;
  always_comb begin
    rs = {r_q, a_q[NW-1]};
    ge = rs >= {1'b0, d_q};
    rn = ge ? DW'(rs - {1'b0, d_q}) : rs[DW-1:0];
    last = busy_q && cnt_q == CW'(NW - 1);
    a_d = start ? (num[NW-1] ? -num : num) : busy_q ? {a_q[NW-2:0], ge} : a_q;
    r_d = start ? '0 : busy_q ? rn : r_q;
    d_d = start ? (den[DW-1] ? -den : den) : d_q;
    cnt_d = start ? '0 : busy_q ? cnt_q + 1'b1 : cnt_q;
    busy_d = start | (busy_q & ~last);
    done_d = ~start & (done_q | last);
    qneg_d = start ? num[NW-1] ^ den[DW-1] : qneg_q;
    rneg_d = start ? num[NW-1] : rneg_q;
  end
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      r_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      a_q <= a_d;
      r_q <= r_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign quo = qneg_q ? -a_q : a_q;
  assign rem = rneg_q ? -r_q : r_q;
endmodule

// File: rtl/fir3_inverse.sv
// fir3_inverse: recovers x[n] = (y[n] - h1*x[n-1] - h2*x[n-2]) / h0 from a 3-tap FIR output.
module fir3_inverse
  import fir_pkg::*;
(
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [YW-1:0] y_in,
  input  logic signed [HW-1:0] h0,
  input  logic signed [HW-1:0] h1,
  input  logic signed [HW-1:0] h2,
  input  logic                 hist_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [XW-1:0] x_out,
  output logic                 out_inexact,
  output logic                 out_ovf,
  output logic                 out_err
);
  state_t state_q, state_d;
  logic signed [YW-1:0] y_q, y_d, r, quo;
  logic signed [HW-1:0] h0_q, h0_d, h1_q, h1_d, h2_q, h2_d, div_rem;
  logic signed [XW-1:0] x1_q, x1_d, x2_q, x2_d, x_q, x_d, q_lo;
  logic signed [HW+XW-1:0] p1, p2;
  logic inexact_q, inexact_d, ovf_q, ovf_d, err_q, err_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic h0_zero, accept, clr, hs, div_start, div_exit, div_busy, div_done;
  always_comb begin
    p1 = h1_q * x1_q;
    p2 = h2_q * x2_q;
    r = y_q - YW'(p1) - YW'(p2);
    h0_zero = h0_q == '0;
    q_lo = quo[XW-1:0];
    accept = state_q == IDLE && in_valid;
    clr = state_q == IDLE && hist_clr;
    hs = state_q == DONE && out_ready;
    div_start = state_q == SUB && !h0_zero && !div_busy;
    // a zero divisor skips the divider but still spends one cycle in DIV
    div_exit = state_q == DIV && (h0_zero || div_done);
    state_d = accept ? SUB : state_q == SUB ? DIV : div_exit ? DONE : hs ? IDLE : state_q;
    y_d = accept ? y_in : y_q;
    h0_d = accept ? h0 : h0_q;
    h1_d = accept ? h1 : h1_q;
    h2_d = accept ? h2 : h2_q;
    x1_d = clr ? '0 : hs ? x_q : x1_q;
    x2_d = clr ? '0 : hs ? x1_q : x2_q;
    x_d = div_exit ? (h0_zero ? '0 : q_lo) : x_q;
    inexact_d = div_exit ? !h0_zero && div_rem != '0 : inexact_q;
    ovf_d = div_exit ? !h0_zero && quo != YW'(q_lo) : ovf_q;
    err_d = div_exit ? h0_zero : err_q;
    in_ready_d = state_d == IDLE;
    out_valid_d = state_d == DONE;
  end
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      y_q <= '0;
      h0_q <= '0;
      h1_q <= '0;
      h2_q <= '0;
      x1_q <= '0;
      x2_q <= '0;
      x_q <= '0;
      inexact_q <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q <= y_d;
      h0_q <= h0_d;
      h1_q <= h1_d;
      h2_q <= h2_d;
      x1_q <= x1_d;
      x2_q <= x2_d;
      x_q <= x_d;
      inexact_q <= inexact_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
  fir_seq_div #(.NW(YW), .DW(HW)) u_div (
    .CLK(CLK), .rst(rst), .start(div_start), .num(r), .den(h0_q),
    .busy(div_busy), .done(div_done), .quo(quo), .rem(div_rem)
  );
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign x_out = x_q;
  assign out_inexact = inexact_q;
  assign out_ovf = ovf_q;
  assign out_err = err_q;
endmodule

// File: tb/tb_fir3_inverse.sv
// tb_fir3_inverse: table-driven check of recovered samples, flags and latency, plus backpressure and reset sequences.
module tb_fir3_inverse;
  import fir_pkg::*;
  logic CLK = 1'b0, rst = 1'b1, in_valid = 1'b0, hist_clr = 1'b0, out_ready = 1'b0;
  logic signed [YW-1:0] y_in = '0;
  logic signed [HW-1:0] h0 = '0, h1 = '0, h2 = '0;
  logic in_ready, out_valid, out_inexact, out_ovf, out_err;
  logic signed [XW-1:0] x_out;
  int errors = 0, checks = 0;

  typedef struct {
    logic signed [YW-1:0] y;
    logic signed [HW-1:0] a, b, c;
    logic clr;
    logic signed [XW-1:0] x;
    logic inx, ovf, err;
  } vec_t;
  vec_t v[15];

  always #5 CLK = ~CLK;

  fir3_inverse dut (
    .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .y_in(y_in),
    .h0(h0), .h1(h1), .h2(h2), .hist_clr(hist_clr), .out_valid(out_valid),
    .out_ready(out_ready), .x_out(x_out), .out_inexact(out_inexact),
    .out_ovf(out_ovf), .out_err(out_err)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input vec_t t, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    chk("in_ready_idle", in_ready, 1);
    y_in = t.y; h0 = t.a; h1 = t.b; h2 = t.c; hist_clr = t.clr; in_valid = 1'b1;
    step();
    in_valid = 1'b0; hist_clr = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    vec_t t;
    v[0]  = '{32'sd5, 16'sd1, 16'sd2, 16'sd3, 1'b1, 16'sd5, 1'b0, 1'b0, 1'b0};
    v[1]  = '{32'sd3, 16'sd1, 16'sd2, 16'sd3, 1'b0, -16'sd7, 1'b0, 1'b0, 1'b0};
    v[2]  = '{32'sd101, 16'sd1, 16'sd2, 16'sd3, 1'b0, 16'sd100, 1'b0, 1'b0, 1'b0};
    v[3]  = '{32'sd12, 16'sd4, 16'sd0, 16'sd0, 1'b0, 16'sd3, 1'b0, 1'b0, 1'b0};
    v[4]  = '{32'sd13, 16'sd4, 16'sd0, 16'sd0, 1'b0, 16'sd3, 1'b1, 1'b0, 1'b0};
    v[5]  = '{-32'sd13, 16'sd4, 16'sd0, 16'sd0, 1'b0, -16'sd3, 1'b1, 1'b0, 1'b0};
    v[6]  = '{32'sd77, 16'sd0, 16'sd0, 16'sd0, 1'b0, 16'sd0, 1'b0, 1'b0, 1'b1};
    v[7]  = '{32'sh0001_0000, 16'sd1, 16'sd0, 16'sd0, 1'b0, 16'sh0000, 1'b0, 1'b1, 1'b0};
    v[8]  = '{-32'sd32768, 16'sd1, 16'sd0, 16'sd0, 1'b0, 16'sh8000, 1'b0, 1'b0, 1'b0};
    v[9]  = '{32'sd32768, 16'sd1, 16'sd0, 16'sd0, 1'b0, 16'sh8000, 1'b0, 1'b1, 1'b0};
    v[10] = '{32'sd10, -16'sd3, 16'sd0, 16'sd0, 1'b0, -16'sd3, 1'b1, 1'b0, 1'b0};
    v[11] = '{32'sd5, 16'sd1, 16'sd2, 16'sd3, 1'b1, 16'sd5, 1'b0, 1'b0, 1'b0};
    v[12] = '{32'sd20, 16'sd2, 16'sd1, 16'sd0, 1'b0, 16'sd7, 1'b1, 1'b0, 1'b0};
    v[13] = '{-32'sd7, -16'sd2, 16'sd0, 16'sd0, 1'b0, 16'sd3, 1'b1, 1'b0, 1'b0};
    v[14] = '{32'sh8000_0000, 16'sd1, 16'sd0, 16'sd0, 1'b0, 16'sh0000, 1'b0, 1'b1, 1'b0};

    #1 rst = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_flags", {out_inexact, out_ovf, out_err}, 0);
    repeat (2) step();
    chk("rst_in_ready_held", in_ready, 0);
    rst = 1'b1;
    step();
    chk("in_ready_after_rst", in_ready, 1);

    for (int i = 0; i < 15; i++) begin
      send(v[i], lat);
      chk($sformatf("lat[%0d]", i), lat, v[i].err ? 2 : 2 + DIV_CYC);
      chk($sformatf("x_out[%0d]", i), x_out, v[i].x);
      chk($sformatf("inexact[%0d]", i), out_inexact, v[i].inx);
      chk($sformatf("ovf[%0d]", i), out_ovf, v[i].ovf);
      chk($sformatf("err[%0d]", i), out_err, v[i].err);
      consume();
      chk($sformatf("idle_after[%0d]", i), {out_valid, in_ready}, 2'b01);
    end

    t = '{32'sd7, 16'sd1, 16'sd0, 16'sd0, 1'b0, 16'sd7, 1'b0, 1'b0, 1'b0};
    send(t, lat);
    chk("bp_lat", lat, 2 + DIV_CYC);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid_ready", {out_valid, in_ready}, 2'b10);
      chk("bp_x_out", x_out, 7);
      chk("bp_flags", {out_inexact, out_ovf, out_err}, 0);
    end
    consume();
    chk("bp_release", {out_valid, in_ready}, 2'b01);

    t = '{32'sd99, 16'sd1, 16'sd2, 16'sd3, 1'b0, 16'sd0, 1'b0, 1'b0, 1'b0};
    y_in = t.y; h0 = t.a; h1 = t.b; h2 = t.c; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (11) begin
      step();
      chk("abort_no_valid_pre", out_valid, 0);
    end
    rst = 1'b0;
    #1;
    chk("abort_outputs", {out_valid, in_ready, out_inexact, out_ovf, out_err}, 0);
    chk("abort_x_out", x_out, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_valid", out_valid, 0);
    end
    rst = 1'b1;
    step();
    chk("abort_in_ready", in_ready, 1);
    t = '{32'sd5, 16'sd1, 16'sd2, 16'sd3, 1'b0, 16'sd5, 1'b0, 1'b0, 1'b0};
    send(t, lat);
    chk("post_rst_lat", lat, 2 + DIV_CYC);
    chk("post_rst_x_out", x_out, 5);
    chk("post_rst_flags", {out_inexact, out_ovf, out_err}, 0);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
